mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/mem_ctrl_ram.sv | 32 +++
 rtl/mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the mem_ctrl memory controller slice.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_ctrl_ram.sv
// Single-clock RAM with one synchronous write port and one synchronous read port.
// Contents are deliberately not reset.
module mem_ctrl_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// CPU/loader memory controller with a 4-phase CPU handshake and shared data bus.
// Optional access wait states are enabled by defining MEM_CTRL_WAIT_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_req,
  input  logic              we,
  inout  wire  [DATA_W-1:0] data,
  output logic              mem_ready,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ack
);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              drive_q;

  logic              accept;
  logic              load;
  logic              cpu_wr;
  logic              wait_last;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

`ifdef MEM_CTRL_WAIT_EN
  localparam bit WAIT_GO = (WAIT_CYCLES > 0);
  localparam int CNT_W   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign wait_last = (state_q == WAIT) && (cnt_q == CNT_W'(1));
`else
  // WAIT_CYCLES has no effect without the wait feature; WAIT is never entered.
  localparam bit WAIT_GO = 1'b0 && (WAIT_CYCLES > 0);

  assign wait_last = 1'b0;
`endif

  assign accept = (state_q == IDLE) && mem_req;
  assign load   = (state_q == IDLE) && !mem_req && prog_we;
  assign cpu_wr = (state_q == ACCESS) && we_q;

  assign ram_we    = load || cpu_wr;
  assign ram_waddr = cpu_wr ? addr_q  : prog_addr;
  assign ram_wdata = cpu_wr ? wdata_q : prog_data;

  // Fetch one cycle early so the RAM output is ready when ACCESS captures rdata.
  assign ram_re    = (accept && !we && !WAIT_GO) || (wait_last && !we_q);
  assign ram_raddr = (state_q == IDLE) ? addr : addr_q;

  assign data = drive_q ? rdata_q : {DATA_W{1'bz}};

  mem_ctrl_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Controller FSM with registered handshake, bus-drive and loader-ack outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      drive_q   <= 1'b0;
      mem_ready <= 1'b0;
      prog_ack  <= 1'b0;
`ifdef MEM_CTRL_WAIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      prog_ack <= load;
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            addr_q <= addr;
            we_q   <= we;
            if (we) begin
              wdata_q <= data;
            end
            if (WAIT_GO) begin
              state_q <= WAIT;
`ifdef MEM_CTRL_WAIT_EN
              cnt_q   <= CNT_W'(WAIT_CYCLES);
`endif
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        WAIT: begin
`ifdef MEM_CTRL_WAIT_EN
          cnt_q <= cnt_q - CNT_W'(1);
          if (wait_last) begin
            state_q <= ACCESS;
          end
`else
          state_q <= ACCESS;
`endif
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= ram_rdata;
          end
          drive_q   <= !we_q;
          mem_ready <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          if (!mem_req) begin
            drive_q   <= 1'b0;
            mem_ready <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          drive_q   <= 1'b0;
          mem_ready <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized traffic
// against an array-based memory model; honours MEM_CTRL_WAIT_EN with WAIT_CYCLES=3.
module tb_mem_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int WC = 3;
`ifdef MEM_CTRL_WAIT_EN
  localparam int LAT = 2 + WC;
`else
  localparam int LAT = 2;
`endif
  // An undriven bus floats to all ones through the pullup.
  localparam logic [DW-1:0] ZVAL = 8'hFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] addr = 8'h00;
  logic          mem_req = 1'b0;
  logic          we = 1'b0;
  logic [DW-1:0] cpu_data = 8'h00;
  logic          cpu_drive = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = 8'h00;
  logic [DW-1:0] prog_data = 8'h00;
  wire  [DW-1:0] data;
  wire           mem_ready;
  wire           prog_ack;

  assign data = cpu_drive ? cpu_data : 8'hzz;
  pullup pu_data (data);

  mem_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .mem_req   (mem_req),
    .we        (we),
    .data      (data),
    .mem_ready (mem_ready),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_ack  (prog_ack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] ref_mem [2**AW];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic loader_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    #1 check("prog_ack_pulse", prog_ack, 1);
    ref_mem[a] = d;
    @(negedge clk);
    #1 check("prog_ack_clear", prog_ack, 0);
  endtask

  // One full 4-phase CPU access; with_load raises prog_we together with mem_req.
  task automatic cpu_access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int hold, input bit with_load);
    logic [DW-1:0] exp_v;
    int cyc;
    bit seen;
    @(negedge clk);
    addr = a; we = w; mem_req = 1'b1; cpu_data = d; cpu_drive = w;
    if (with_load) prog_we = 1'b1;
    exp_v = w ? ZVAL : ref_mem[a];
    @(posedge clk);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      addr = 8'($urandom); we = 1'($urandom); cpu_data = ~d;
      if (cyc >= 2) cpu_drive = 1'b0;
      #1;
      if (mem_ready) seen = 1'b1;
      else if (!cpu_drive) check("bus_z_busy", data, ZVAL);
    end
    check("latency", cyc, LAT);
    check("done_data", data, exp_v);
    check("ack_busy", prog_ack, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1 check("ready_hold", mem_ready, 1);
      check("hold_data", data, exp_v);
    end
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    #1 check("ready_fall", mem_ready, 0);
    check("bus_z_idle", data, ZVAL);
    if (w) ref_mem[a] = d;
  endtask

  initial begin
    int cyc;
    // Reset state
    @(negedge clk);
    #1 check("rst_ready", mem_ready, 0);
    check("rst_ack", prog_ack, 0);
    check("rst_bus_z", data, ZVAL);
    @(negedge clk);
    rst = 1'b1;

    // Initialise every word through the loader so the model is fully known
    for (int i = 0; i < 2**AW; i++) loader_write(8'(i), 8'($urandom));

    // Loader writes then CPU readback
    loader_write(8'hE0, 8'h01);
    loader_write(8'hE2, 8'h00);
    cpu_access(1'b0, 8'hE0, 8'h00, 0, 1'b0);
    check("read_E0", ref_mem[8'hE0], 8'h01);
    cpu_access(1'b0, 8'hE2, 8'h00, 0, 1'b0);

    // CPU write then readback
    cpu_access(1'b1, 8'h10, 8'h55, 0, 1'b0);
    cpu_access(1'b0, 8'h10, 8'h00, 0, 1'b0);

    // CPU and loader collide in IDLE: CPU first, loader afterwards
    prog_addr = 8'h03; prog_data = 8'hAA;
    cpu_access(1'b0, 8'h02, 8'h00, 0, 1'b1);
    cyc = 0;
    while (!prog_ack && cyc < 5) begin
      @(negedge clk);
      cyc++;
      #1;
    end
    prog_we = 1'b0;
    check("collide_ack_delay", cyc, 1);
    ref_mem[8'h03] = 8'hAA;
    @(negedge clk);
    #1 check("collide_ack_clear", prog_ack, 0);
    cpu_access(1'b0, 8'h03, 8'h00, 0, 1'b0);

    // Reset during an in-flight write must abort it
    loader_write(8'h20, 8'h11);
    @(negedge clk);
    addr = 8'h20; we = 1'b1; cpu_data = 8'h77; cpu_drive = 1'b1; mem_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cpu_drive = 1'b0;
    #1 check("abort_ready", mem_ready, 0);
    check("abort_bus_z", data, ZVAL);
    check("abort_ack", prog_ack, 0);
    mem_req = 1'b0;
    @(negedge clk);
    #1 check("abort_ready_hold", mem_ready, 0);
    rst = 1'b1;
    cpu_access(1'b0, 8'h20, 8'h00, 0, 1'b0);

    // mem_req held after completion: ready persists, no second access
    cpu_access(1'b0, 8'hE0, 8'h00, 4, 1'b0);
    repeat (3) begin
      @(negedge clk);
      #1 check("no_second_access", mem_ready, 0);
    end

    // Randomized mix of loader and CPU traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        loader_write(8'($urandom), 8'($urandom));
      else
        cpu_access(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
